// File: rtl/ssd_scanner.sv
// Multiplexed seven-segment display scanner with frame-synchronous data commit and PWM dimming.
// Optional macro SSD_BLINK_EN adds a per-digit blink mask driven by a 64-frame counter.
module ssd_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_PER    = 10,
    parameter int REFR_RATE  = 1000,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink,
`endif
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic                    frame_done
);

    localparam longint FRAME_DIV   = longint'(CLK_PER) * longint'(REFR_RATE) * longint'(NUM_DIGITS);
    localparam longint TICKS_RAW   = 64'sd1000000000 / FRAME_DIV;
    localparam int     DIGIT_TICKS = (TICKS_RAW < 64'sd1) ? 1 : int'(TICKS_RAW);
    localparam int     TICK_W      = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int     IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [7:0] seg_decode(input logic [3:0] hex, input logic point);
        logic [7:0] seg;
        seg = 8'hFF;
        case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        if (point) seg[7] = 1'b0;
        return seg;
    endfunction

    logic [TICK_W-1:0]       tick;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_W-1:0]     pwm;
    logic [4*NUM_DIGITS-1:0] act_digits, stg_digits;
    logic [NUM_DIGITS-1:0]   act_dp, stg_dp;
    logic [NUM_DIGITS-1:0]   act_blank, stg_blank;
    logic                    pending;

    logic       slot_end;
    logic       wrap;
    logic       pwm_on;
    logic       digit_on;
    logic [3:0] nibble;

`ifdef SSD_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
        end else if (wrap) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end
`endif

    always_comb begin
        slot_end = (tick == TICK_W'(DIGIT_TICKS - 1));
        wrap     = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
        // All-ones brightness means fully on; zero never lights because pwm < 0 is impossible.
        pwm_on   = (brightness == '1) || (pwm < brightness);
        nibble   = act_digits[4*idx +: 4];
        digit_on = pwm_on && !act_blank[idx];
`ifdef SSD_BLINK_EN
        if (blink[idx] && frame_cnt[5]) digit_on = 1'b0;
`endif
    end

    // Scan timing: slot tick counter, digit index and free-running PWM counter
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            tick <= '0;
            idx  <= '0;
            pwm  <= '0;
        end else begin
            pwm <= pwm + 1'b1;
            if (slot_end) begin
                tick <= '0;
                idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

    // Staging/active double buffer; the active copy only changes on a frame wrap so a
    // frame is never drawn with a mix of old and new data.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_blank  <= '0;
            pending    <= 1'b0;
        end else begin
            if (wrap && pending) begin
                act_digits <= stg_digits;
                act_dp     <= stg_dp;
                act_blank  <= stg_blank;
            end
            if (load) begin
                stg_digits <= digits;
                stg_dp     <= dp;
                stg_blank  <= blank;
                pending    <= 1'b1;
            end else if (wrap) begin
                pending    <= 1'b0;
            end
        end
    end

    // Output stage: one cycle behind the scan state
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            anode      <= '1;
            cathode    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            anode      <= digit_on ? ~(NUM_DIGITS'(1) << idx) : '1;
            cathode    <= digit_on ? seg_decode(nibble, act_dp[idx]) : 8'hFF;
        end
    end

endmodule

// File: tb/tb_ssd_scanner.sv
// Scoreboard bench for ssd_scanner: a cycle-count reference model queues expected outputs,
// a separate monitor pops and compares them one cycle after each clock edge.
module tb_ssd_scanner;

    localparam int N     = 4;
    localparam int BW    = 2;
    localparam int DT    = 4;
    localparam int FRAME = N * DT;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [15:0]   digits;
    logic [3:0]    dp;
    logic [3:0]    blank;
    logic          load;
    logic [1:0]    brightness;
    logic [3:0]    anode;
    logic [7:0]    cathode;
    logic          frame_done;

    always #5 Clk = ~Clk;

    ssd_scanner #(
        .NUM_DIGITS(N),
        .CLK_PER   (10),
        .REFR_RATE (6250000),
        .BRIGHT_W  (BW)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .digits    (digits),
        .dp        (dp),
        .blank     (blank),
        .load      (load),
        .brightness(brightness),
        .anode     (anode),
        .cathode   (cathode),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] ca;
        logic       fd;
        int         stamp;
    } exp_t;

    exp_t q[$];

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int checks = 0;
    int passes = 0;
    int stamp  = 0;

    // Reference state: cycles since reset, displayed frame data, staged data
    int          cyc = 0;
    logic [15:0] act_dg = '0, stg_dg = '0;
    logic [3:0]  act_dp = '0, stg_dp = '0;
    logic [3:0]  act_bl = '0, stg_bl = '0;
    bit          pend = 0;

    logic [15:0] cur_dg = '0;
    logic [3:0]  cur_dp = '0;
    logic [3:0]  cur_bl = '0;
    logic [1:0]  cur_br = 2'd3;

    task automatic chk(input string name, input int s, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s at step %0d: got %h, want %h", name, s, got, want);
    endtask

    task automatic step(input logic r, input logic ld);
        exp_t e;
        int   idx, pw;
        bit   on, lit, wrap;
        Reset_n    = r;
        load       = ld;
        digits     = cur_dg;
        dp         = cur_dp;
        blank      = cur_bl;
        brightness = cur_br;
        if (!r) begin
            e.an = 4'hF; e.ca = 8'hFF; e.fd = 1'b0;
            cyc = 0; pend = 0;
            act_dg = '0; act_dp = '0; act_bl = '0;
            stg_dg = '0; stg_dp = '0; stg_bl = '0;
        end else begin
            idx  = (cyc / DT) % N;
            pw   = cyc % (1 << BW);
            on   = (cur_br == 2'b11) || (pw < int'(cur_br));
            lit  = on && !act_bl[idx];
            e.an = lit ? 4'(~(4'b0001 << idx)) : 4'hF;
            e.ca = lit ? (seg_tab[act_dg[4*idx +: 4]] & (act_dp[idx] ? 8'h7F : 8'hFF)) : 8'hFF;
            wrap = (cyc % FRAME) == FRAME - 1;
            e.fd = wrap;
            if (wrap && pend) begin
                act_dg = stg_dg; act_dp = stg_dp; act_bl = stg_bl;
                pend = 0;
            end
            if (ld) begin
                stg_dg = cur_dg; stg_dp = cur_dp; stg_bl = cur_bl;
                pend = 1;
            end
            cyc++;
        end
        e.stamp = stamp;
        stamp++;
        q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    // Monitor: expectations pushed before an edge are due after that edge
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                @(negedge Clk);
                chk("anode", e.stamp, {4'h0, anode}, {4'h0, e.an});
                chk("cathode", e.stamp, cathode, e.ca);
                chk("frame_done", e.stamp, {7'h0, frame_done}, {7'h0, e.fd});
            end
        end
    end

    initial begin
        Reset_n = 1'b0; load = 1'b0; digits = '0; dp = '0; blank = '0; brightness = 2'd3;
        @(posedge Clk);
        #1;
        repeat (3) step(1'b0, 1'b0);

        cur_dg = 16'h4321; cur_dp = 4'b0000; cur_bl = 4'b0000; cur_br = 2'd3;
        step(1'b1, 1'b1);
        run(40);

        cur_dg = 16'h4320; cur_dp = 4'b0001;
        step(1'b1, 1'b1);
        run(36);

        cur_dp = 4'b0000; cur_bl = 4'b0100;
        step(1'b1, 1'b1);
        run(36);

        cur_bl = 4'b0000;
        step(1'b1, 1'b1);
        cur_br = 2'd1;
        run(36);
        cur_br = 2'd0;
        run(20);
        cur_br = 2'd3;
        run(20);

        cur_dg = 16'hAAAA;
        step(1'b1, 1'b1);
        run(4);
        cur_dg = 16'hBBBB;
        step(1'b1, 1'b1);
        run(40);

        cur_dg = 16'h1234;
        step(1'b1, 1'b1);
        run(3);
        step(1'b0, 1'b0);
        run(40);

        for (int i = 0; i < 3000; i++) begin
            logic r, ld;
            r  = ($urandom_range(0, 299) != 0);
            ld = ($urandom_range(0, 7) == 0);
            if (ld) begin
                cur_dg = 16'($urandom);
                cur_dp = 4'($urandom);
                cur_bl = 4'($urandom & $urandom);
            end
            if ($urandom_range(0, 39) == 0) cur_br = 2'($urandom_range(0, 3));
            step(r, ld);
        end

        repeat (2) @(negedge Clk);
        chk("drain", stamp, 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
